spi_master_tx: RTL and testbench

//  SPI master (mode 0: CPOL=0, CPHA=0, MSB first), the initiator end of the link that spi_interface receives.
//  - Accepts a parallel word on a valid/ready handshake.
//  - Generates spi_clk/spi_cs_n, shifts the word out on spi_mosi and captures spi_miso into rx_data.
//  - Sits between the host-side control logic and the off-block SPI pins; one word per chip-select frame.

---
 rtl/spi_master_tx.sv | 143 ++++++++++++++
 tb/tb_spi_master_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: one WIDTH-bit word per chip-select frame, MSB first,
// full duplex (spi_miso captured on every spi_clk rise), all outputs registered.
module spi_master_tx #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 100
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs_n
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]   rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               cs_n_q, cs_n_d;
  logic               tx_ready_q, tx_ready_d;

  logic tick, last_bit, accept;

  assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_bit = (bit_cnt_q == CNT_W'(WIDTH));
  assign accept   = tx_valid && tx_ready_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SETUP;
      S_SETUP: if (tick)   state_d = S_HIGH;
      S_HIGH:  if (tick)   state_d = S_LOW;
      S_LOW:   if (tick)   state_d = last_bit ? S_GAP : S_HIGH;
      S_GAP:   if (tick)   state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    div_d      = (state_q == S_IDLE || tick) ? '0 : div_q + DIV_W'(1);
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    tx_ready_d = tx_ready_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tx_shift_d = tx_data;
          mosi_d     = tx_data[WIDTH-1];
          cs_n_d     = 1'b0;
          tx_ready_d = 1'b0;
          bit_cnt_d  = '0;
        end
      end
      S_SETUP, S_LOW: begin
        if (tick) begin
          if (state_q == S_LOW && last_bit) begin
            // Final low half-period was the CS hold time: close the frame.
            cs_n_d     = 1'b1;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
          end else begin
            sclk_d     = 1'b1;
            rx_shift_d = {rx_shift_q[WIDTH-2:0], spi_miso};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      S_HIGH: begin
        if (tick) begin
          sclk_d     = 1'b0;
          tx_shift_d = tx_shift_q << 1;
          mosi_d     = last_bit ? 1'b0 : tx_shift_q[WIDTH-2];
        end
      end
      S_GAP: begin
        if (tick) tx_ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: a 32-bit/CLK_DIV=4 instance with MISO
// loopback (or tied high) and an 8-bit/CLK_DIV=2 instance, watched by a per-cycle monitor.
module tb_spi_master_tx;

  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic        miso_tie;
  logic        sel_b;

  logic [31:0] tx_data_a;
  logic        tx_valid_a, tx_ready_a, rx_valid_a, sclk_a, mosi_a, miso_a, cs_a;
  logic [31:0] rx_data_a;
  logic [7:0]  tx_data_b, rx_data_b;
  logic        tx_valid_b, tx_ready_b, rx_valid_b, sclk_b, mosi_b, miso_b, cs_b;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  assign miso_a = miso_tie ? 1'b1 : mosi_a;
  assign miso_b = mosi_b;

  spi_master_tx #(.WIDTH(32), .CLK_DIV(4)) dut_a (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .spi_clk(sclk_a), .spi_mosi(mosi_a), .spi_miso(miso_a), .spi_cs_n(cs_a)
  );

  spi_master_tx #(.WIDTH(8), .CLK_DIV(2)) dut_b (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .spi_clk(sclk_b), .spi_mosi(mosi_b), .spi_miso(miso_b), .spi_cs_n(cs_b)
  );

  // Monitor view of whichever instance is under test.
  logic        m_cs, m_sclk, m_mosi, m_rxv, m_ready;
  logic [31:0] m_rx;
  assign m_cs    = sel_b ? cs_b       : cs_a;
  assign m_sclk  = sel_b ? sclk_b     : sclk_a;
  assign m_mosi  = sel_b ? mosi_b     : mosi_a;
  assign m_rxv   = sel_b ? rx_valid_b : rx_valid_a;
  assign m_ready = sel_b ? tx_ready_b : tx_ready_a;
  assign m_rx    = sel_b ? {24'h0, rx_data_b} : rx_data_a;

  int          cs_low, cs_falls, high_run, gap_min, rises, proto_err, mosi_high, rxv_cnt;
  logic [63:0] mosi_bits;
  logic [31:0] rx_first, rx_last;
  logic        prev_cs, prev_sclk, prev_mosi;

  task automatic clr_mon();
    cs_low = 0; cs_falls = 0; high_run = 0; gap_min = 1000; rises = 0;
    proto_err = 0; mosi_high = 0; rxv_cnt = 0; mosi_bits = '0;
    rx_first = '0; rx_last = '0;
    prev_cs = m_cs; prev_sclk = m_sclk; prev_mosi = m_mosi;
  endtask

  task automatic step();
    @(negedge sys_clk);
    if (!m_cs) cs_low++;
    if (!m_cs && prev_cs) begin
      cs_falls++;
      if (cs_falls > 1 && high_run < gap_min) gap_min = high_run;
    end
    if (m_cs) high_run++; else high_run = 0;
    if (m_sclk && !prev_sclk) begin
      rises++;
      mosi_bits = {mosi_bits[62:0], m_mosi};
    end
    if (m_sclk && m_mosi !== prev_mosi) proto_err++;
    if (m_sclk && m_cs) proto_err++;
    if (m_cs !== prev_cs && (m_sclk || prev_sclk)) proto_err++;
    if (m_mosi) mosi_high++;
    if (m_rxv) begin
      rxv_cnt++;
      if (rxv_cnt == 1) rx_first = m_rx;
      rx_last = m_rx;
    end
    prev_cs = m_cs; prev_sclk = m_sclk; prev_mosi = m_mosi;
  endtask

  task automatic start_frame(input logic [31:0] d);
    if (sel_b) begin tx_data_b = d[7:0]; tx_valid_b = 1'b1; end
    else       begin tx_data_a = d;      tx_valid_a = 1'b1; end
    step();
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!m_ready && n < 1000) begin step(); n++; end
    checks++;
    if (!m_ready) begin failures++; $display("FAIL %s_timeout: tx_ready=%b required 1", name, m_ready); end
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    step(); step();
    checks++; if (cs_a !== 1'b1 || cs_b !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b/%b required 1/1", cs_a, cs_b); end
    checks++; if (sclk_a !== 1'b0 || mosi_a !== 1'b0) begin failures++; $display("FAIL reset_clk_mosi: got %b/%b required 0/0", sclk_a, mosi_a); end
    checks++; if (tx_ready_a !== 1'b1 || rx_valid_a !== 1'b0) begin failures++; $display("FAIL reset_ready_valid: got %b/%b required 1/0", tx_ready_a, rx_valid_a); end
    checks++; if (rx_data_a !== 32'h0) begin failures++; $display("FAIL reset_rx_data: got %h required 00000000", rx_data_a); end
    sys_reset = 1'b0;
    step();
  endtask

  task automatic test_loopback();
    clr_mon();
    start_frame(32'hdeadbeef);
    wait_idle("loopback");
    checks++; if (rxv_cnt != 1 || rx_last !== 32'hdeadbeef) begin failures++; $display("FAIL loopback_rx: got %h (%0d pulses) required deadbeef (1)", rx_last, rxv_cnt); end
    checks++; if (mosi_bits[31:0] !== 32'hdeadbeef) begin failures++; $display("FAIL loopback_mosi: got %h required deadbeef", mosi_bits[31:0]); end
    checks++; if (rises != 32) begin failures++; $display("FAIL loopback_rises: got %0d required 32", rises); end
    checks++; if (cs_low != 260) begin failures++; $display("FAIL loopback_cs_low: got %0d required 260", cs_low); end
    checks++; if (proto_err != 0) begin failures++; $display("FAIL loopback_protocol: got %0d errors required 0", proto_err); end
    repeat (10) step();
    checks++; if (rx_data_a !== 32'hdeadbeef) begin failures++; $display("FAIL rx_data_hold: got %h required deadbeef", rx_data_a); end
  endtask

  task automatic test_miso_high();
    miso_tie = 1'b1;
    clr_mon();
    start_frame(32'h0);
    wait_idle("miso_high");
    checks++; if (mosi_high != 0) begin failures++; $display("FAIL zero_mosi: got %0d high cycles required 0", mosi_high); end
    checks++; if (rx_last !== 32'hffffffff) begin failures++; $display("FAIL miso_high_rx: got %h required ffffffff", rx_last); end
    miso_tie = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    clr_mon();
    tx_data_a = 32'h12345678; tx_valid_a = 1'b1;
    step();
    tx_data_a = 32'hcafef00d;
    n = 0;
    while (!m_ready && n < 1000) begin step(); n++; end
    step();
    tx_valid_a = 1'b0;
    wait_idle("b2b");
    checks++; if (rxv_cnt != 2) begin failures++; $display("FAIL b2b_rx_count: got %0d required 2", rxv_cnt); end
    checks++; if (rx_first !== 32'h12345678 || rx_last !== 32'hcafef00d) begin failures++; $display("FAIL b2b_rx_data: got %h %h required 12345678 cafef00d", rx_first, rx_last); end
    checks++; if (mosi_bits !== 64'h12345678cafef00d) begin failures++; $display("FAIL b2b_mosi: got %h required 12345678cafef00d", mosi_bits); end
    checks++; if (cs_falls != 2 || gap_min < 5) begin failures++; $display("FAIL b2b_gap: got %0d frames gap %0d required 2 frames gap>=5", cs_falls, gap_min); end
  endtask

  task automatic test_ignore_busy();
    clr_mon();
    start_frame(32'ha5c30f96);
    repeat (40) step();
    tx_data_a = 32'h0; tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    checks++; if (tx_ready_a !== 1'b0) begin failures++; $display("FAIL busy_ready: got %b required 0", tx_ready_a); end
    wait_idle("busy");
    checks++; if (mosi_bits[31:0] !== 32'ha5c30f96) begin failures++; $display("FAIL busy_mosi: got %h required a5c30f96", mosi_bits[31:0]); end
    checks++; if (rxv_cnt != 1 || cs_falls != 1) begin failures++; $display("FAIL busy_frames: got %0d rx %0d frames required 1 1", rxv_cnt, cs_falls); end
    repeat (10) step();
    checks++; if (cs_falls != 1) begin failures++; $display("FAIL busy_queued: got %0d frames required 1", cs_falls); end
  endtask

  task automatic test_abort();
    int n;
    clr_mon();
    start_frame(32'hdeadbeef);
    n = 0;
    while (rises < 10 && n < 1000) begin step(); n++; end
    sys_reset = 1'b1;
    step();
    sys_reset = 1'b0;
    checks++; if (cs_a !== 1'b1 || sclk_a !== 1'b0 || mosi_a !== 1'b0) begin failures++; $display("FAIL abort_pins: got cs=%b clk=%b mosi=%b required 1 0 0", cs_a, sclk_a, mosi_a); end
    checks++; if (tx_ready_a !== 1'b1 || rx_valid_a !== 1'b0) begin failures++; $display("FAIL abort_handshake: got %b/%b required 1/0", tx_ready_a, rx_valid_a); end
    clr_mon();
    repeat (300) step();
    checks++; if (rxv_cnt != 0 || cs_falls != 0) begin failures++; $display("FAIL abort_quiet: got %0d rx %0d frames required 0 0", rxv_cnt, cs_falls); end
    clr_mon();
    start_frame(32'h0f0f1234);
    wait_idle("after_abort");
    checks++; if (rx_last !== 32'h0f0f1234 || rises != 32 || cs_low != 260) begin failures++; $display("FAIL after_abort: got rx=%h rises=%0d cs_low=%0d required 0f0f1234 32 260", rx_last, rises, cs_low); end
  endtask

  task automatic test_small();
    sel_b = 1'b1;
    clr_mon();
    start_frame(32'h000000a5);
    wait_idle("small");
    checks++; if (mosi_bits[7:0] !== 8'ha5 || rises != 8) begin failures++; $display("FAIL small_mosi: got %h (%0d rises) required a5 (8)", mosi_bits[7:0], rises); end
    checks++; if (cs_low != 34) begin failures++; $display("FAIL small_cs_low: got %0d required 34", cs_low); end
    checks++; if (proto_err != 0) begin failures++; $display("FAIL small_protocol: got %0d errors required 0", proto_err); end
    checks++; if (rx_last !== 32'h000000a5 || rxv_cnt != 1) begin failures++; $display("FAIL small_rx: got %h (%0d) required 000000a5 (1)", rx_last, rxv_cnt); end
    sel_b = 1'b0;
  endtask

  initial begin
    sys_reset = 1'b1; miso_tie = 1'b0; sel_b = 1'b0;
    tx_data_a = '0; tx_valid_a = 1'b0; tx_data_b = '0; tx_valid_b = 1'b0;
    test_reset();
    test_loopback();
    test_miso_high();
    test_back_to_back();
    test_ignore_busy();
    test_abort();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
